// File: rtl/mac_array.sv
// mac_array: LANES-wide multiply-accumulate, ACC_LEN beats per frame, ready/valid on both sides.
// Define MAC_SATURATE_EN to clamp the frame result to OUT_W bits instead of wrapping.
module mac_array #(
    parameter int LANES   = 3,
    parameter int DATA_W  = 8,
    parameter int ACC_LEN = 3,
    parameter int OUT_W   = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*DATA_W-1:0] in_weight,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    acc_clr,
    output logic signed [OUT_W-1:0] out_result,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int PW = 2*DATA_W + 1;
    localparam int SW = PW + $clog2(LANES);
    localparam int AW = SW + $clog2(ACC_LEN);
    localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;
    logic signed [PW-1:0]    lane_d, lane_w;
    logic signed [SW-1:0]    beat_sum, psum;
    logic signed [AW-1:0]    acc, acc_next;
    logic signed [OUT_W-1:0] fmt_val;
    logic [CW-1:0]           beat_cnt;
    logic                    p_valid, p_last, s2_adv, take, cnt_last, fire_last;
    // a completed frame may only overwrite the output once the held result is taken
    assign s2_adv    = p_valid && !(p_last && out_valid && !out_ready);
    assign in_ready  = rst && !acc_clr && (!p_valid || s2_adv);
    assign take      = in_valid && in_ready;
    assign cnt_last  = beat_cnt == CW'(ACC_LEN - 1);
    assign fire_last = s2_adv && p_last && !acc_clr;
    assign acc_next  = acc + AW'(psum);
    always_comb begin
        lane_d   = '0;
        lane_w   = '0;
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_d   = PW'($signed({1'b0, in_data[i*DATA_W +: DATA_W]}));
            lane_w   = PW'($signed(in_weight[i*DATA_W +: DATA_W]));
            beat_sum = beat_sum + SW'(lane_d * lane_w);
        end
    end
`ifdef MAC_SATURATE_EN
    localparam int XW = AW > OUT_W ? AW : OUT_W;
    localparam logic signed [XW-1:0] MAX_V = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_V = ~MAX_V;
    logic signed [XW-1:0] wide;
    logic                 clamp_hi, clamp_lo, sat_seen;
    assign wide     = XW'(acc_next);
    assign clamp_hi = wide > MAX_V;
    assign clamp_lo = wide < MIN_V;
    assign fmt_val  = clamp_hi ? OUT_W'(MAX_V) : clamp_lo ? OUT_W'(MIN_V) : OUT_W'(wide);
    always_ff @(posedge clk) begin
        if (!rst)
            sat_seen <= 1'b0;
        else
            sat_seen <= sat_seen || (fire_last && (clamp_hi || clamp_lo));
    end
`else
    assign fmt_val = OUT_W'(acc_next);
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            p_valid    <= 1'b0;
            p_last     <= 1'b0;
            psum       <= '0;
            beat_cnt   <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (acc_clr) begin
                p_valid  <= 1'b0;
                beat_cnt <= '0;
                acc      <= '0;
            end else begin
                if (take) begin
                    psum     <= beat_sum;
                    p_last   <= cnt_last;
                    beat_cnt <= cnt_last ? '0 : beat_cnt + CW'(1);
                end
                p_valid <= take || (p_valid && !s2_adv);
                if (s2_adv)
                    acc <= p_last ? '0 : acc_next;
            end
            out_valid  <= fire_last ? 1'b1 : out_valid && !out_ready;
            out_result <= fire_last ? fmt_val : out_result;
        end
    end
endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: scoreboard bench for mac_array; a second instance with OUT_W=18 covers result formatting.
module tb_mac_array;
    localparam logic [23:0] D1 = 24'h010203, W1 = 24'h040506;
    localparam logic [23:0] DA = 24'h0A141E, WA = 24'hFD02FF;
    localparam logic [23:0] DF = 24'hFFFFFF, WN = 24'h808080;
`ifdef MAC_SATURATE_EN
    localparam logic [17:0] E18 = 18'h20000;
`else
    localparam logic [17:0] E18 = 18'h38480;
`endif
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, acc_clr, out_valid, out_ready;
    logic        in_ready18, out_valid18;
    logic [23:0] in_data, in_weight;
    logic [19:0] out_result;
    logic [17:0] out_result18;
    logic [19:0] exp_q[$];
    int          checks = 0, errors = 0, frame_acc = 0, beat_n = 0;

    mac_array dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_weight(in_weight),
        .in_valid(in_valid), .in_ready(in_ready), .acc_clr(acc_clr),
        .out_result(out_result), .out_valid(out_valid), .out_ready(out_ready)
    );
    mac_array #(.OUT_W(18)) dut18 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_weight(in_weight),
        .in_valid(in_valid), .in_ready(in_ready18), .acc_clr(acc_clr),
        .out_result(out_result18), .out_valid(out_valid18), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int beat_val(input logic [23:0] d, input logic [23:0] w);
        int s = 0;
        for (int i = 0; i < 3; i++)
            s += int'(d[i*8 +: 8]) * int'($signed(w[i*8 +: 8]));
        return s;
    endfunction

    function automatic logic [19:0] fmt20(input int v);
        logic [31:0] u = v;
`ifdef MAC_SATURATE_EN
        if (v > 524287) return 20'h7FFFF;
        if (v < -524288) return 20'h80000;
`endif
        return u[19:0];
    endfunction

    // scoreboard: every output handshake must match the oldest expected frame
    always @(negedge clk) begin
        #2;
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected got %0d expected none", $signed(out_result));
            end else if (out_result !== exp_q[0]) begin
                errors++;
                $display("FAIL result got %0d expected %0d", $signed(out_result), $signed(exp_q[0]));
                void'(exp_q.pop_front());
            end else
                void'(exp_q.pop_front());
        end
    end

    task automatic send_beat(input logic [23:0] d, input logic [23:0] w);
        int t = 0;
        in_data = d;
        in_weight = w;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            if (++t > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got in_ready=0 expected 1");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        frame_acc += beat_val(d, w);
        beat_n++;
        if (beat_n == 3) begin
            exp_q.push_back(fmt20(frame_acc));
            frame_acc = 0;
            beat_n = 0;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        in_data = '0; in_weight = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
        if (out_result !== 20'd0) begin errors++; $display("FAIL rst_out_result got %h expected 0", out_result); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b expected 0", in_ready); end
        if (in_ready18 !== 1'b0) begin errors++; $display("FAIL rst_in_ready18 got %b expected 0", in_ready18); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        repeat (3) send_beat(D1, W1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b expected 0", out_valid); end
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b expected 1", out_valid); end
        if (out_result !== 20'd96) begin errors++; $display("FAIL basic_result got %0d expected 96", $signed(out_result)); end
        drain();
    endtask

    task automatic test_wide();
        out_ready = 1'b1;
        repeat (3) send_beat(DF, WN);
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid got %b expected 1", out_valid); end
        if (out_result !== 20'hB8480) begin errors++; $display("FAIL wide_result got %h expected b8480", out_result); end
        if (out_valid18 !== 1'b1) begin errors++; $display("FAIL fmt18_valid got %b expected 1", out_valid18); end
        if (out_result18 !== E18) begin errors++; $display("FAIL fmt18_result got %h expected %h", out_result18, E18); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        repeat (3) send_beat(D1, W1);
        repeat (3) send_beat(DA, WA);
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b expected 0", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b expected 1", out_valid); end
        if (out_result !== 20'd96) begin errors++; $display("FAIL hold_result got %0d expected 96", $signed(out_result)); end
        repeat (3) @(negedge clk);
        checks += 2;
        if (out_result !== 20'd96) begin errors++; $display("FAIL hold_stable got %0d expected 96", $signed(out_result)); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_stable got %b expected 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b expected 1", out_valid); end
        if (out_result !== 20'hFFFC4) begin errors++; $display("FAIL b2b_second got %0d expected -60", $signed(out_result)); end
        drain();
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        repeat (3) send_beat(D1, W1);
        repeat (2) send_beat(DA, WA);
        acc_clr = 1'b1;
        in_data = D1;
        in_weight = W1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %b expected 0", in_ready); end
        @(negedge clk);
        acc_clr = 1'b0;
        in_valid = 1'b0;
        frame_acc = 0;
        beat_n = 0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_keeps_valid got %b expected 1", out_valid); end
        if (out_result !== 20'd96) begin errors++; $display("FAIL clr_keeps_result got %0d expected 96", $signed(out_result)); end
        out_ready = 1'b1;
        repeat (3) send_beat(D1, W1);
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        repeat (3) send_beat(D1, W1);
        send_beat(DA, WA);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pend_valid got %b expected 1", out_valid); end
        rst = 1'b0;
        exp_q.delete();
        frame_acc = 0;
        beat_n = 0;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b expected 0", out_valid); end
        if (out_result !== 20'd0) begin errors++; $display("FAIL mid_rst_result got %h expected 0", out_result); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b expected 0", in_ready); end
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) send_beat(DA, WA);
        @(negedge clk);
        checks++;
        if (out_result !== 20'hFFFC4) begin errors++; $display("FAIL after_rst_result got %0d expected -60", $signed(out_result)); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
